pipeline_stage_ctrl: RTL and testbench
======================================

PIPELINE_STAGE_CTRL -- requirements
Module: pipeline_stage_ctrl

Interface
REQ-001 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-002 nRST  input  1  reset, synchronous, active-low; sampled only on posedge CLK.
REQ-003 ihit  input  1  instruction fetch completes this cycle.
REQ-004 dhit  input  1  data access completes this cycle.
REQ-005 dmemREN_mem, dmemWEN_mem  input  1 each  MEM-stage load/store request.
REQ-006 MemRead_ex  input  1  EX-stage instruction is a load.
REQ-007 rt_ex, rs_id, rt_id  input  5 each  register indices for load-use detection.
REQ-008 branch_taken_ex  input  1  EX-stage branch/jump redirects the PC.
REQ-009 halt_wb  input  1  halt instruction has reached WB.
REQ-010 pc_en  output  1  PC update enable.
REQ-011 en_fd, en_de, en_em, en_mw  output  1 each  pipeline latch enables.
REQ-012 flush_fd, flush_de, flush_em, flush_mw  output  1 each  latch clears; flush overrides enable in the latches.
REQ-013 dmem_busy  output  1  high while in DWAIT.
REQ-014 stall_cnt  output  32  stall-cycle counter; present only with PSC_STALL_CNT_EN.

Function
REQ-015 The FSM SHALL have states RUN, DWAIT and HALT in a 2-bit register.
REQ-016 Derived terms: dreq = dmemREN_mem | dmemWEN_mem; dok = !dreq | dhit; adv = ihit & dok.
REQ-017 Load-use (lu) SHALL be MemRead_ex & (rt_ex != 0) & (rt_ex == rs_id | rt_ex == rt_id).
REQ-018 Outputs SHALL be combinational from the current state and inputs; all outputs not listed in a rule are 0.
REQ-019 RUN with adv, no lu, no branch: pc_en and all four en_* = 1.
REQ-020 RUN with adv and branch_taken_ex: as REQ-019 plus flush_fd = flush_de = 1; branch overrides lu.
REQ-021 RUN with adv and lu, no branch: pc_en = en_fd = 0, flush_de = 1, en_em = en_mw = 1 (one bubble).
REQ-022 RUN with dreq & dhit & !ihit: en_mw = 1 and flush_em = 1; PC, FD and DE hold.
REQ-023 RUN or DWAIT with !dok: all enables 0 (full freeze).
REQ-024 RUN with dok & !ihit & !dreq: all enables 0.
REQ-025 Transitions: RUN->DWAIT on dreq & !dhit; DWAIT->RUN on dhit; any state->HALT when halt_wb = 1 (highest priority); HALT is left only by reset.
REQ-026 DWAIT with dhit SHALL apply the REQ-019 to REQ-022 rules as if in RUN.
REQ-027 HALT: all enables and flushes 0; dmem_busy 0.
REQ-028 A halt_wb cycle itself SHALL drive all enables 0 so that nothing behind the halt advances.

Reset
REQ-029 While nRST = 0 at an edge: state <= RUN and stall_cnt <= 0.
REQ-030 While nRST = 0: pc_en = 0, all en_* = 0, all flush_* = 1, dmem_busy = 0.
REQ-031 Reset asserted mid-DWAIT or in HALT SHALL return to RUN at that edge; the pending access is abandoned.

Configuration
REQ-032 Macro PSC_STALL_CNT_EN SHALL control the stall counter.
REQ-033 With the macro defined: stall_cnt increments each cycle pc_en = 0 outside HALT and reset, and saturates at 32'hFFFFFFFF.
REQ-034 Without the macro: the stall_cnt port and counter are absent; all other behaviour is identical.

Verification
REQ-035 Reset then ihit = 1, dreq = 0 -> pc_en and all en_* = 1; no flush; state RUN.
REQ-036 dmemREN_mem = 1, dhit = 0 for 3 cycles, then dhit = 1 -> dmem_busy high for 3 cycles with full freeze; RUN after dhit; stall_cnt = 3 (macro on).
REQ-037 MemRead_ex = 1, rt_ex = 5, rs_id = 5, ihit = 1 -> one cycle with pc_en = en_fd = 0 and flush_de = 1; rt_ex = 0 gives no bubble.
REQ-038 branch_taken_ex = 1 together with a load-use match -> flush_fd = flush_de = 1 and pc_en = 1; no lu bubble.
REQ-039 halt_wb = 1 -> all outputs 0 from that cycle; ihit/dhit toggling has no effect; nRST = 0 for one edge -> RUN.
REQ-040 dreq = 1, dhit = 1, ihit = 0 -> en_mw = 1, flush_em = 1, pc_en = en_fd = en_de = 0.

Source files
------------

// File: rtl/pipeline_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_stage_ctrl_if
//
// Purpose:
//   Bundles the hazard/handshake inputs seen by the pipeline stage controller
//   and the latch-control outputs it produces. Clock and reset are not part of
//   the bundle; they are wired as plain ports on the controller.
//
// Signals (direction as seen by the controller, i.e. the slave modport):
//   in : ihit             instruction fetch completes this cycle
//   in : dhit             data access completes this cycle
//   in : dmemREN_mem      MEM-stage load request
//   in : dmemWEN_mem      MEM-stage store request
//   in : MemRead_ex       EX-stage instruction is a load
//   in : rt_ex[4:0]       EX-stage load destination register
//   in : rs_id[4:0]       ID-stage source register 1
//   in : rt_id[4:0]       ID-stage source register 2
//   in : branch_taken_ex  EX-stage branch/jump redirects the PC
//   in : halt_wb          halt instruction has reached WB
//   out: pc_en            PC update enable
//   out: en_fd/de/em/mw   pipeline latch enables
//   out: flush_fd/de/em/mw pipeline latch clears (override enables)
//   out: dmem_busy        controller is waiting on a data access
//
// Modports:
//   master : pipeline / environment side (drives hazard inputs)
//   slave  : controller side
// -----------------------------------------------------------------------------
interface pipeline_stage_ctrl_if;

    logic       ihit;
    logic       dhit;
    logic       dmemREN_mem;
    logic       dmemWEN_mem;
    logic       MemRead_ex;
    logic [4:0] rt_ex;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic       branch_taken_ex;
    logic       halt_wb;

    logic       pc_en;
    logic       en_fd;
    logic       en_de;
    logic       en_em;
    logic       en_mw;
    logic       flush_fd;
    logic       flush_de;
    logic       flush_em;
    logic       flush_mw;
    logic       dmem_busy;

    modport master (
        output ihit,
        output dhit,
        output dmemREN_mem,
        output dmemWEN_mem,
        output MemRead_ex,
        output rt_ex,
        output rs_id,
        output rt_id,
        output branch_taken_ex,
        output halt_wb,
        input  pc_en,
        input  en_fd,
        input  en_de,
        input  en_em,
        input  en_mw,
        input  flush_fd,
        input  flush_de,
        input  flush_em,
        input  flush_mw,
        input  dmem_busy
    );

    modport slave (
        input  ihit,
        input  dhit,
        input  dmemREN_mem,
        input  dmemWEN_mem,
        input  MemRead_ex,
        input  rt_ex,
        input  rs_id,
        input  rt_id,
        input  branch_taken_ex,
        input  halt_wb,
        output pc_en,
        output en_fd,
        output en_de,
        output en_em,
        output en_mw,
        output flush_fd,
        output flush_de,
        output flush_em,
        output flush_mw,
        output dmem_busy
    );

endinterface

// File: rtl/pipeline_stage_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stage_ctrl
//
// Purpose:
//   Central stall/flush controller for a classic 5-stage pipeline. It combines
//   instruction/data memory readiness, load-use hazards, taken branches and
//   halt into PC/latch enables and latch flushes.
//
//   A small FSM tracks whether the pipeline is running (RUN), waiting for an
//   outstanding data access (DWAIT) or halted (HALT). The control outputs are
//   combinational from the current state and the inputs, so a hazard seen in a
//   cycle acts on the latches at the end of that same cycle.
//
// Ports:
//   CLK        in   sole clock, rising edge
//   nRST       in   synchronous active-low reset
//   stall_cnt  out  [31:0] saturating stall-cycle counter (optional, see below)
//   bus        slave modport of pipeline_stage_ctrl_if (hazard inputs and
//              PC/latch control outputs)
//
// Configuration:
//   PSC_STALL_CNT_EN  when defined, adds the stall_cnt port and counter. It
//                     counts cycles with pc_en low while not halted and not in
//                     reset, saturating at all-ones. When undefined, the port
//                     and counter are absent and all other behaviour is the
//                     same.
// -----------------------------------------------------------------------------
module pipeline_stage_ctrl (
    input  logic                  CLK,
    input  logic                  nRST,
`ifdef PSC_STALL_CNT_EN
    output logic [31:0]           stall_cnt,
`endif
    pipeline_stage_ctrl_if.slave  bus
);

    // -------------------------------------------------------------------------
    // State encoding. Encoding 2'b11 is unused; it is treated as a freeze and
    // recovers to RUN on the next edge.
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Control word, MSB first, matching the order of the output port list.
    typedef struct packed {
        logic pc_en;
        logic en_fd;
        logic en_de;
        logic en_em;
        logic en_mw;
        logic flush_fd;
        logic flush_de;
        logic flush_em;
        logic flush_mw;
        logic dmem_busy;
    } ctrl_t;

    // Everything held, nothing cleared.
    localparam ctrl_t CTRL_FREEZE  = 10'b00000_0000_0;
    // Reset: hold everything and clear every latch.
    localparam ctrl_t CTRL_RESET   = 10'b00000_1111_0;
    // Normal advance of the whole pipe.
    localparam ctrl_t CTRL_ADVANCE = 10'b11111_0000_0;
    // Taken branch: advance, but squash the two wrong-path instructions.
    localparam ctrl_t CTRL_BRANCH  = 10'b11111_1100_0;
    // Load-use: hold PC and FD, insert a bubble into DE, let EX/MEM move on.
    localparam ctrl_t CTRL_BUBBLE  = 10'b00011_0100_0;
    // Data done but fetch not: retire MEM into WB, leave a bubble in EM.
    localparam ctrl_t CTRL_DRAIN   = 10'b00001_0010_0;

    state_e state_q;
    ctrl_t  ctrl_s;

    logic   dreq_s;
    logic   dok_s;
    logic   adv_s;
    logic   lu_s;

    // -------------------------------------------------------------------------
    // Load-use hazard: the EX-stage load writes a register the ID-stage
    // instruction reads. Register 0 is hardwired and never creates a hazard.
    // -------------------------------------------------------------------------
    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] rt_ex,
        input logic [4:0] rs_id,
        input logic [4:0] rt_id
    );
        return mem_read & (rt_ex != 5'd0) & ((rt_ex == rs_id) | (rt_ex == rt_id));
    endfunction

    // -------------------------------------------------------------------------
    // Control word for an active (non-halted) cycle. Shared by RUN and DWAIT:
    // in DWAIT the access is still requested, so without dhit dok is low and
    // the result is a full freeze; with dhit it behaves exactly like RUN.
    // Branch wins over load-use because the instruction in ID is on the wrong
    // path anyway and is squashed.
    // -------------------------------------------------------------------------
    function automatic ctrl_t active_ctrl(
        input logic dok,
        input logic adv,
        input logic dreq,
        input logic branch,
        input logic lu
    );
        ctrl_t c;
        c = CTRL_FREEZE;
        if (!dok) begin
            c = CTRL_FREEZE;
        end else if (adv) begin
            if (branch) begin
                c = CTRL_BRANCH;
            end else if (lu) begin
                c = CTRL_BUBBLE;
            end else begin
                c = CTRL_ADVANCE;
            end
        end else if (dreq) begin
            // dok with a request means dhit; only ihit is missing.
            c = CTRL_DRAIN;
        end else begin
            c = CTRL_FREEZE;
        end
        return c;
    endfunction

    // Derived readiness terms and hazard detection.
    always_comb begin
        dreq_s = bus.dmemREN_mem | bus.dmemWEN_mem;
        dok_s  = ~dreq_s | bus.dhit;
        adv_s  = bus.ihit & dok_s;
        lu_s   = load_use(bus.MemRead_ex, bus.rt_ex, bus.rs_id, bus.rt_id);
    end

    // Control word decode from current state and inputs. Reset dominates,
    // then a halt reaching WB freezes everything in its own cycle.
    always_comb begin
        ctrl_s = CTRL_FREEZE;
        if (!nRST) begin
            ctrl_s = CTRL_RESET;
        end else if (bus.halt_wb) begin
            ctrl_s = CTRL_FREEZE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    ctrl_s = active_ctrl(dok_s, adv_s, dreq_s, bus.branch_taken_ex, lu_s);
                end
                ST_DWAIT: begin
                    ctrl_s           = active_ctrl(dok_s, adv_s, dreq_s, bus.branch_taken_ex, lu_s);
                    ctrl_s.dmem_busy = 1'b1;
                end
                ST_HALT: begin
                    ctrl_s = CTRL_FREEZE;
                end
                default: begin
                    ctrl_s = CTRL_FREEZE;
                end
            endcase
        end
    end

    // FSM state register with transitions; halt has priority, reset beats all.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ST_RUN;
        end else if (bus.halt_wb) begin
            state_q <= ST_HALT;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (dreq_s && !bus.dhit) begin
                        state_q <= ST_DWAIT;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DWAIT: begin
                    if (bus.dhit) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_DWAIT;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.pc_en     = ctrl_s.pc_en;
    assign bus.en_fd     = ctrl_s.en_fd;
    assign bus.en_de     = ctrl_s.en_de;
    assign bus.en_em     = ctrl_s.en_em;
    assign bus.en_mw     = ctrl_s.en_mw;
    assign bus.flush_fd  = ctrl_s.flush_fd;
    assign bus.flush_de  = ctrl_s.flush_de;
    assign bus.flush_em  = ctrl_s.flush_em;
    assign bus.flush_mw  = ctrl_s.flush_mw;
    assign bus.dmem_busy = ctrl_s.dmem_busy;

`ifdef PSC_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles the PC is held, excluding HALT and reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt_q <= 32'd0;
        end else if ((state_q != ST_HALT) && !ctrl_s.pc_en &&
                     (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stage_ctrl
//
// Directed bench for pipeline_stage_ctrl. Each step drives one cycle of inputs
// after the falling edge, queues the expected control word, and compares it
// shortly afterwards, well clear of the rising edge. Expected words are
// constants written from the required behaviour.
// Control word order: {pc_en, en_fd, en_de, en_em, en_mw,
//                      flush_fd, flush_de, flush_em, flush_mw, dmem_busy}.
// With PSC_STALL_CNT_EN defined the stall counter is also checked.
// -----------------------------------------------------------------------------
module tb_pipeline_stage_ctrl;

    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    pipeline_stage_ctrl_if bus ();

`ifdef PSC_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    pipeline_stage_ctrl dut (
        .CLK       (CLK),
        .nRST      (nRST),
`ifdef PSC_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .bus       (bus)
    );

    localparam logic [9:0] W_FRZ  = 10'b00000_0000_0;
    localparam logic [9:0] W_RST  = 10'b00000_1111_0;
    localparam logic [9:0] W_ALL  = 10'b11111_0000_0;
    localparam logic [9:0] W_BR   = 10'b11111_1100_0;
    localparam logic [9:0] W_LU   = 10'b00011_0100_0;
    localparam logic [9:0] W_DNI  = 10'b00001_0010_0;
    localparam logic [9:0] W_BUSY = 10'b00000_0000_1;

    logic [9:0] exp_q [$];
    string      tag_q [$];
    int         pass_cnt  = 0;
    int         check_cnt = 0;

    function automatic logic [9:0] observed();
        return {bus.pc_en, bus.en_fd, bus.en_de, bus.en_em, bus.en_mw,
                bus.flush_fd, bus.flush_de, bus.flush_em, bus.flush_mw,
                bus.dmem_busy};
    endfunction

    task automatic step(
        input logic       rst_n,
        input logic       ih,
        input logic       dh,
        input logic       ren,
        input logic       wen,
        input logic       mr,
        input logic [4:0] rtex,
        input logic [4:0] rsid,
        input logic [4:0] rtid,
        input logic       br,
        input logic       halt,
        input logic [9:0] expv,
        input string      tag
    );
        logic [9:0] e;
        logic [9:0] obs;
        string      t;
        @(negedge CLK);
        nRST                = rst_n;
        bus.ihit            = ih;
        bus.dhit            = dh;
        bus.dmemREN_mem     = ren;
        bus.dmemWEN_mem     = wen;
        bus.MemRead_ex      = mr;
        bus.rt_ex           = rtex;
        bus.rs_id           = rsid;
        bus.rt_id           = rtid;
        bus.branch_taken_ex = br;
        bus.halt_wb         = halt;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        #1;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = observed();
        check_cnt++;
        assert (obs === e) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", t, obs, e);
    endtask

`ifdef PSC_STALL_CNT_EN
    task automatic check_stall(input logic [31:0] e, input string tag);
        check_cnt++;
        assert (stall_cnt === e) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, stall_cnt, e);
    endtask
`endif

    initial begin
        nRST                = 1'b0;
        bus.ihit            = 1'b0;
        bus.dhit            = 1'b0;
        bus.dmemREN_mem     = 1'b0;
        bus.dmemWEN_mem     = 1'b0;
        bus.MemRead_ex      = 1'b0;
        bus.rt_ex           = 5'd0;
        bus.rs_id           = 5'd0;
        bus.rt_id           = 5'd0;
        bus.branch_taken_ex = 1'b0;
        bus.halt_wb         = 1'b0;

        // Reset outputs, even with active inputs.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_RST, "reset0");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, W_RST, "reset1");

        // Plain advance after reset.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_ALL, "run_basic");
`ifdef PSC_STALL_CNT_EN
        check_stall(32'd0, "stall_after_reset");
`endif

        // Load miss for three cycles, then hit.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_FRZ, "dwait_enter");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_BUSY, "dwait_1");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_BUSY, "dwait_2");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_ALL | W_BUSY, "dwait_hit");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_ALL, "dwait_exit");
`ifdef PSC_STALL_CNT_EN
        check_stall(32'd3, "stall_after_dwait");
`endif

        // Fetch not done, and data-done-without-fetch drains MEM.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_FRZ, "no_ihit");
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_DNI, "drain_load");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_DNI, "drain_store");

        // Load-use detection variants.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, W_LU, "lu_rs");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, W_LU, "lu_rt");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_ALL, "lu_r0");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, W_ALL, "no_load");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, W_ALL, "lu_miss");

        // Branches.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, W_BR, "br_over_lu");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, W_BR, "br");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, W_FRZ, "br_no_ihit");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, W_FRZ, "br_dmiss");

        // Now in DWAIT: hit with a load-use applies the bubble rule.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, W_LU | W_BUSY, "dwait_hit_lu");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_ALL, "run_again");

        // Halt arriving while in DWAIT, then sticky until reset.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_FRZ, "pre_halt");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, W_FRZ, "halt_cycle");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_FRZ, "halted_a");
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_FRZ, "halted_b");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, W_FRZ, "halted_c");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_RST, "halt_rst");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_ALL, "post_halt");

        // Reset in the middle of a data wait abandons it.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_FRZ, "rd_enter");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_BUSY, "rd_wait");
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_RST, "rd_rst");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, W_FRZ, "rd_run");
`ifdef PSC_STALL_CNT_EN
        check_stall(32'd0, "stall_after_rd_rst");
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
